// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes and FSM state encoding shared by the multiply/divide unit, decoder and hazard unit
package mdu_pkg;
  localparam logic [3:0] NOP   = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MTHI  = 4'd5;
  localparam logic [3:0] MTLO  = 4'd6;
  localparam logic [3:0] MADD  = 4'd7;
  localparam logic [3:0] MADDU = 4'd8;
  typedef enum logic {IDLE, RUN} mdu_state_t;
endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: EX-stage request and HI/LO/busy return bundle for the multiply/divide unit
interface mult_div_unit_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit product and quotient/remainder from the latched operands
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem
);
  logic sx, sd;
  logic [31:0] ma, mb, uq, ur;
  // signed divide works on magnitudes so 0x80000000 / -1 yields 0x80000000 without overflow
  always_comb begin
    sx   = op == MULT || op == MADD;
    sd   = op == DIV;
    prod = {{32{sx & a[31]}}, a} * {{32{sx & b[31]}}, b};
    ma   = sd && a[31] ? -a : a;
    mb   = sd && b[31] ? -b : b;
    uq   = mb == '0 ? '0 : ma / mb;
    ur   = mb == '0 ? '0 : ma % mb;
    quot = sd && (a[31] ^ b[31]) ? -uq : uq;
    rem  = sd && a[31] ? -ur : ur;
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: fixed-latency MIPS mult/div unit owning HI/LO; busy stalls HI/LO users.
// Define MDU_MADD_EN to add the MADD/MADDU accumulate ops (otherwise their codes act as NOP).
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  mdu_state_t state;
  logic [CW-1:0] cnt;
  logic [3:0] op_r;
  logic [31:0] a_r, b_r, hi_r, lo_r, quot, rem;
  logic [63:0] prod;
  logic is_div, is_madd, is_mul;
  always_comb begin
    is_div = bus.op == DIV || bus.op == DIVU;
`ifdef MDU_MADD_EN
    is_madd = bus.op == MADD || bus.op == MADDU;
`else
    is_madd = 1'b0;
`endif
    is_mul = bus.op == MULT || bus.op == MULTU || is_madd;
  end
  mdu_arith u_arith (.op(op_r), .a(a_r), .b(b_r), .prod(prod), .quot(quot), .rem(rem));
  // requests are only looked at in IDLE, so a start during or at the end of RUN is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_r  <= NOP;
      a_r   <= '0;
      b_r   <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
    end else if (state == IDLE) begin
      if (bus.start && (is_mul || is_div)) begin
        state <= RUN;
        op_r  <= bus.op;
        a_r   <= bus.a;
        b_r   <= bus.b;
        cnt   <= is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
      end else if (bus.start && bus.op == MTHI) hi_r <= bus.a;
      else if (bus.start && bus.op == MTLO) lo_r <= bus.a;
    end else if (cnt != '0) cnt <= cnt - CW'(1);
    else begin
      state <= IDLE;
      if (op_r == DIV || op_r == DIVU) begin
        if (b_r != '0) {hi_r, lo_r} <= {rem, quot};
      end else if (op_r == MADD || op_r == MADDU) {hi_r, lo_r} <= {hi_r, lo_r} + prod;
      else {hi_r, lo_r} <= prod;
    end
  end
  assign bus.busy = state == RUN;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit; expected HI/LO pushed at issue, popped at completion
module tb_mult_div_unit;
  import mdu_pkg::*;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  mult_div_unit_if bus ();
  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int fails = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_v;
  int n;

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(negedge clk);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 1;
    while (bus.busy && cyc < 200) begin
      @(negedge clk);
      if (bus.busy) cyc++;
    end
  endtask

  task automatic test_reset();
    int c;
    issue(MTHI, 32'h1234_5678, 0);
    issue(MTLO, 32'h9ABC_DEF0, 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    checks++; if (bus.hi !== 32'h0) begin fails++; $display("FAIL reset_hi got %h want %h", bus.hi, 32'h0); end
    checks++; if (bus.lo !== 32'h0) begin fails++; $display("FAIL reset_lo got %h want %h", bus.lo, 32'h0); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    issue(DIV, 32'd100, 32'd7);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", bus.busy); end
    c = 0;
    repeat (14) begin @(negedge clk); if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) c++; end
    checks++; if (c != 0) begin fails++; $display("FAIL abort_no_writeback got %0d bad cycles want 0 (hi %h lo %h)", c, bus.hi, bus.lo); end
  endtask

  task automatic test_mult();
    logic [3:0] ops[2] = '{MULT, MULTU};
    logic [63:0] exps[2] = '{64'hFFFF_FFFF_FFFF_FFFA, 64'h0000_0002_FFFF_FFFA};
    logic [31:0] x, y;
    logic [3:0] o;
    int c;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(exps[i]);
      issue(ops[i], 32'hFFFF_FFFE, 32'd3);
      wait_idle(c);
      exp_v = sb.pop_front();
      checks++; if (c != 5) begin fails++; $display("FAIL mult%0d_busy_cycles got %0d want 5", i, c); end
      checks++; if ({bus.hi, bus.lo} !== exp_v) begin fails++; $display("FAIL mult%0d_result got %h want %h", i, {bus.hi, bus.lo}, exp_v); end
    end
    for (int i = 0; i < 6; i++) begin
      x = $urandom; y = $urandom; o = i[0] ? MULTU : MULT;
      sb.push_back(o == MULT ? 64'(longint'($signed(x)) * longint'($signed(y))) : {32'h0, x} * {32'h0, y});
      issue(o, x, y);
      wait_idle(c);
      exp_v = sb.pop_front();
      checks++; if ({bus.hi, bus.lo} !== exp_v) begin fails++; $display("FAIL mult_rand op %0d a %h b %h got %h want %h", o, x, y, {bus.hi, bus.lo}, exp_v); end
    end
  endtask

  task automatic test_div();
    logic [3:0] ops[3] = '{DIV, DIVU, DIV};
    logic [31:0] xs[3] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
    logic [31:0] ys[3] = '{32'd2, 32'd2, 32'hFFFF_FFFF};
    logic [63:0] exps[3] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_0000_0003, 64'h0000_0000_8000_0000};
    logic [31:0] x, y;
    logic [3:0] o;
    longint q, r;
    int c;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(exps[i]);
      issue(ops[i], xs[i], ys[i]);
      wait_idle(c);
      exp_v = sb.pop_front();
      checks++; if (c != 10) begin fails++; $display("FAIL div%0d_busy_cycles got %0d want 10", i, c); end
      checks++; if ({bus.hi, bus.lo} !== exp_v) begin fails++; $display("FAIL div%0d_result got %h want %h", i, {bus.hi, bus.lo}, exp_v); end
    end
    for (int i = 0; i < 6; i++) begin
      x = $urandom; y = $urandom >> (i * 5); o = i[0] ? DIVU : DIV;
      if (y == 0) y = 32'd3;
      if (o == DIV) begin q = longint'($signed(x)) / longint'($signed(y)); r = longint'($signed(x)) % longint'($signed(y)); end
      else begin q = longint'({32'h0, x}) / longint'({32'h0, y}); r = longint'({32'h0, x}) % longint'({32'h0, y}); end
      sb.push_back({r[31:0], q[31:0]});
      issue(o, x, y);
      wait_idle(c);
      exp_v = sb.pop_front();
      checks++; if ({bus.hi, bus.lo} !== exp_v) begin fails++; $display("FAIL div_rand op %0d a %h b %h got %h want %h", o, x, y, {bus.hi, bus.lo}, exp_v); end
    end
  endtask

  task automatic test_div_zero();
    int c;
    issue(MTHI, 32'h11, 0);
    issue(MTLO, 32'h22, 0);
    sb.push_back({32'h11, 32'h22});
    issue(DIV, 32'd1234, 32'd0);
    wait_idle(c);
    exp_v = sb.pop_front();
    checks++; if (c != 10) begin fails++; $display("FAIL divzero_busy_cycles got %0d want 10", c); end
    checks++; if ({bus.hi, bus.lo} !== exp_v) begin fails++; $display("FAIL divzero_hold got %h want %h", {bus.hi, bus.lo}, exp_v); end
  endtask

  task automatic test_mthi_busy();
    logic [63:0] prev;
    int c, bad;
    prev = {bus.hi, bus.lo};
    sb.push_back(64'(longint'(1234567) * longint'(-89)));
    issue(MULT, 32'd1234567, 32'hFFFF_FFA7);
    bus.start = 1'b1; bus.op = MTHI; bus.a = 32'hDEAD;
    c = 0; bad = 0;
    while (bus.busy && c < 200) begin
      c++;
      if ({bus.hi, bus.lo} !== prev) bad++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    exp_v = sb.pop_front();
    checks++; if (c != 5) begin fails++; $display("FAIL mthi_busy_cycles got %0d want 5", c); end
    checks++; if (bad != 0) begin fails++; $display("FAIL hilo_hold_in_window got %0d changed cycles want 0", bad); end
    checks++; if ({bus.hi, bus.lo} !== exp_v) begin fails++; $display("FAIL mthi_ignored got %h want %h", {bus.hi, bus.lo}, exp_v); end
    @(negedge clk);
    checks++; if (bus.hi !== exp_v[63:32]) begin fails++; $display("FAIL mthi_at_completion got %h want %h", bus.hi, exp_v[63:32]); end
    issue(MTLO, 32'h5A5A_A5A5, 0);
    checks++; if (bus.lo !== 32'h5A5A_A5A5) begin fails++; $display("FAIL mtlo_idle got %h want %h", bus.lo, 32'h5A5A_A5A5); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL mtlo_no_busy got %b want 0", bus.busy); end
    checks++; if (bus.hi !== exp_v[63:32]) begin fails++; $display("FAIL mtlo_hi_kept got %h want %h", bus.hi, exp_v[63:32]); end
  endtask

  task automatic test_madd();
    int c;
    issue(MTHI, 32'h0, 0);
    issue(MTLO, 32'hFFFF_FFFF, 0);
`ifdef MDU_MADD_EN
    sb.push_back(64'h0000_0001_0000_0000);
    issue(MADDU, 32'd1, 32'd1);
    wait_idle(c);
    exp_v = sb.pop_front();
    checks++; if (c != 5) begin fails++; $display("FAIL maddu_busy_cycles got %0d want 5", c); end
    checks++; if ({bus.hi, bus.lo} !== exp_v) begin fails++; $display("FAIL maddu_result got %h want %h", {bus.hi, bus.lo}, exp_v); end
    sb.push_back(64'h0000_0000_FFFF_FFFF);
    issue(MADD, 32'hFFFF_FFFF, 32'd1);
    wait_idle(c);
    exp_v = sb.pop_front();
    checks++; if ({bus.hi, bus.lo} !== exp_v) begin fails++; $display("FAIL madd_result got %h want %h", {bus.hi, bus.lo}, exp_v); end
`else
    sb.push_back(64'h0000_0000_FFFF_FFFF);
    issue(MADDU, 32'd1, 32'd1);
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL maddu_nop_busy got %b want 0", bus.busy); end
    repeat (6) @(negedge clk);
    exp_v = sb.pop_front();
    checks++; if ({bus.hi, bus.lo} !== exp_v) begin fails++; $display("FAIL maddu_nop_hold got %h want %h", {bus.hi, bus.lo}, exp_v); end
`endif
  endtask

  task automatic test_back_to_back();
    int c;
    sb.push_back({32'h0, 32'd12});
    sb.push_back({32'd1, 32'd33});
    issue(MULTU, 32'd3, 32'd4);
    wait_idle(c);
    issue(DIVU, 32'd100, 32'd3);
    checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL b2b_accept got %b want 1", bus.busy); end
    checks++; if ({bus.hi, bus.lo} !== sb[0]) begin fails++; $display("FAIL b2b_first got %h want %h", {bus.hi, bus.lo}, sb[0]); end
    exp_v = sb.pop_front();
    wait_idle(c);
    exp_v = sb.pop_front();
    checks++; if ({bus.hi, bus.lo} !== exp_v) begin fails++; $display("FAIL b2b_second got %h want %h", {bus.hi, bus.lo}, exp_v); end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = NOP; bus.a = '0; bus.b = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_mthi_busy();
    test_madd();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
